iob_rr_arbiter: RTL and testbench

- Registered N-way arbiter that shares one resource (e.g. the ETH TX/RX buffer port or the DMA master) between PORTS requesters.
- Built around iob_priority_encoder instances: one unmasked, one round-robin-masked.
- Produces a one-hot grant, its binary index and a valid flag.
- Optional grant locking until the requester drops its request or pulses an acknowledge.

---
 rtl/iob_rr_arbiter.sv | 144 ++++++++++++++
 tb/tb_iob_rr_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_rr_arbiter.sv
// Registered N-way arbiter, round-robin or fixed priority, with optional grant locking.
// The candidate comes from an unmasked and a round-robin-masked priority encoder.

module iob_priority_encoder #(
  parameter int WIDTH    = 4,
  parameter bit LSB_HIGH = 1'b1,
  parameter int IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] unencoded,
  output logic             valid,
  output logic [IDX_W-1:0] encoded,
  output logic [WIDTH-1:0] onehot
);

  // Scan away from the winning end so the last hit is the highest-priority request
  always_comb begin
    valid   = |unencoded;
    encoded = '0;
    onehot  = '0;
    if (LSB_HIGH) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (unencoded[i]) begin
          encoded   = IDX_W'(i);
          onehot    = '0;
          onehot[i] = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (unencoded[i]) begin
          encoded   = IDX_W'(i);
          onehot    = '0;
          onehot[i] = 1'b1;
        end
      end
    end
  end

endmodule

module iob_rr_arbiter #(
  parameter int    PORTS                = 4,
  parameter int    ARB_TYPE_ROUND_ROBIN = 1,
  parameter string BLOCK                = "NONE",
  parameter string LSB_PRIORITY         = "HIGH",
  localparam int   IDX_W                = (PORTS > 1) ? $clog2(PORTS) : 1
) (
  input  logic             clk_i,
  input  logic             arst_n_i,
  input  logic             cke_i,
  input  logic [PORTS-1:0] request_i,
  input  logic [PORTS-1:0] acknowledge_i,
  output logic [PORTS-1:0] grant_o,
  output logic             grant_valid_o,
  output logic [IDX_W-1:0] grant_encoded_o
);

  localparam bit RR       = (ARB_TYPE_ROUND_ROBIN != 0);
  localparam bit LSB_HIGH = (LSB_PRIORITY == "HIGH");
  localparam bit BLK_REQ  = (BLOCK == "REQUEST");
  localparam bit BLK_ACK  = (BLOCK == "ACKNOWLEDGE");

  typedef enum logic {IDLE, GRANTED} state_t;

  state_t           state_q;
  logic [PORTS-1:0] mask_q;
  logic [PORTS-1:0] masked_req;
  logic [PORTS-1:0] unm_onehot, msk_onehot, cand_onehot, next_mask;
  logic             unm_valid, msk_valid, cand_valid, hold;
  logic [IDX_W-1:0] unm_idx, msk_idx, cand_idx;

  assign masked_req = request_i & mask_q;

  iob_priority_encoder #(
    .WIDTH    (PORTS),
    .LSB_HIGH (LSB_HIGH),
    .IDX_W    (IDX_W)
  ) u_unmasked (
    .unencoded (request_i),
    .valid     (unm_valid),
    .encoded   (unm_idx),
    .onehot    (unm_onehot)
  );

  iob_priority_encoder #(
    .WIDTH    (PORTS),
    .LSB_HIGH (LSB_HIGH),
    .IDX_W    (IDX_W)
  ) u_masked (
    .unencoded (masked_req),
    .valid     (msk_valid),
    .encoded   (msk_idx),
    .onehot    (msk_onehot)
  );

  always_comb begin
    cand_valid  = unm_valid;
    cand_idx    = unm_idx;
    cand_onehot = unm_onehot;
    if (RR && msk_valid) begin
      cand_valid  = 1'b1;
      cand_idx    = msk_idx;
      cand_onehot = msk_onehot;
    end
  end

  // After a grant only ports behind the winner in priority order stay eligible
  always_comb begin
    next_mask = '0;
    for (int i = 0; i < PORTS; i++) begin
      next_mask[i] = LSB_HIGH ? (i > int'(cand_idx)) : (i < int'(cand_idx));
    end
  end

  always_comb begin
    hold = 1'b0;
    if (state_q == GRANTED) begin
      if (BLK_REQ) begin
        hold = |(request_i & grant_o);
      end else if (BLK_ACK) begin
        hold = ~|(acknowledge_i & grant_o);
      end
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q         <= IDLE;
      mask_q          <= '1;
      grant_o         <= '0;
      grant_valid_o   <= 1'b0;
      grant_encoded_o <= '0;
    end else if (cke_i && !hold) begin
      grant_o         <= cand_onehot;
      grant_valid_o   <= cand_valid;
      grant_encoded_o <= cand_idx;
      state_q         <= cand_valid ? GRANTED : IDLE;
      if (RR && cand_valid) begin
        mask_q <= next_mask;
      end
    end
  end

endmodule

// File: tb/tb_iob_rr_arbiter.sv
// Self-checking bench for iob_rr_arbiter: five configurations share one stimulus stream,
// directed vector table first, then random traffic against a cyclic-search reference model.

module tb_iob_rr_arbiter;

  localparam int P    = 4;
  localparam int NCFG = 5;
  // dut0 RR/NONE/HIGH, dut1 fixed/NONE/HIGH, dut2 RR/REQUEST, dut3 RR/ACKNOWLEDGE, dut4 RR/NONE/LOW
  localparam int CFG_RR   [NCFG] = '{1, 0, 1, 1, 1};
  localparam int CFG_BLK  [NCFG] = '{0, 0, 1, 2, 0};
  localparam int CFG_HIGH [NCFG] = '{1, 1, 1, 1, 0};

  logic         clk_i         = 1'b0;
  logic         arst_n_i      = 1'b0;
  logic         cke_i         = 1'b1;
  logic [P-1:0] request_i     = '0;
  logic [P-1:0] acknowledge_i = '0;

  logic [P-1:0] grant [NCFG];
  logic         valid [NCFG];
  logic [1:0]   enc   [NCFG];

  int tests = 0;
  int fails = 0;
  int m_grant [NCFG];
  int m_last  [NCFG];

  typedef struct {
    string        name;
    int           dut;
    bit           rst;
    logic [P-1:0] req;
    logic [P-1:0] ack;
    logic         cke;
    logic [P-1:0] exp_grant;
    logic [1:0]   exp_enc;
  } vec_t;

  vec_t vecs[$];

  always #5 clk_i = ~clk_i;

  iob_rr_arbiter #(.PORTS(P), .ARB_TYPE_ROUND_ROBIN(1), .BLOCK("NONE"), .LSB_PRIORITY("HIGH")) u_dut0 (
    .clk_i(clk_i), .arst_n_i(arst_n_i), .cke_i(cke_i), .request_i(request_i),
    .acknowledge_i(acknowledge_i), .grant_o(grant[0]), .grant_valid_o(valid[0]),
    .grant_encoded_o(enc[0]));

  iob_rr_arbiter #(.PORTS(P), .ARB_TYPE_ROUND_ROBIN(0), .BLOCK("NONE"), .LSB_PRIORITY("HIGH")) u_dut1 (
    .clk_i(clk_i), .arst_n_i(arst_n_i), .cke_i(cke_i), .request_i(request_i),
    .acknowledge_i(acknowledge_i), .grant_o(grant[1]), .grant_valid_o(valid[1]),
    .grant_encoded_o(enc[1]));

  iob_rr_arbiter #(.PORTS(P), .ARB_TYPE_ROUND_ROBIN(1), .BLOCK("REQUEST"), .LSB_PRIORITY("HIGH")) u_dut2 (
    .clk_i(clk_i), .arst_n_i(arst_n_i), .cke_i(cke_i), .request_i(request_i),
    .acknowledge_i(acknowledge_i), .grant_o(grant[2]), .grant_valid_o(valid[2]),
    .grant_encoded_o(enc[2]));

  iob_rr_arbiter #(.PORTS(P), .ARB_TYPE_ROUND_ROBIN(1), .BLOCK("ACKNOWLEDGE"), .LSB_PRIORITY("HIGH")) u_dut3 (
    .clk_i(clk_i), .arst_n_i(arst_n_i), .cke_i(cke_i), .request_i(request_i),
    .acknowledge_i(acknowledge_i), .grant_o(grant[3]), .grant_valid_o(valid[3]),
    .grant_encoded_o(enc[3]));

  iob_rr_arbiter #(.PORTS(P), .ARB_TYPE_ROUND_ROBIN(1), .BLOCK("NONE"), .LSB_PRIORITY("LOW")) u_dut4 (
    .clk_i(clk_i), .arst_n_i(arst_n_i), .cke_i(cke_i), .request_i(request_i),
    .acknowledge_i(acknowledge_i), .grant_o(grant[4]), .grant_valid_o(valid[4]),
    .grant_encoded_o(enc[4]));

  // Winner = first requester met when walking cyclically away from the last winner
  function automatic int pick(input int c, input logic [P-1:0] req, input int last);
    int start;
    int i;
    if (req == '0) return -1;
    if (CFG_RR[c] == 0) last = -1;
    if (CFG_HIGH[c] != 0) start = (last < 0) ? 0 : last + 1;
    else start = (last < 0) ? P - 1 : last - 1;
    for (int n = 0; n < P; n++) begin
      if (CFG_HIGH[c] != 0) i = (start + n) % P;
      else i = (start - n + 2 * P) % P;
      if (req[i]) return i;
    end
    return -1;
  endfunction

  // Reference model: granted port number (-1 = none) and last winner per configuration
  always @(posedge clk_i or negedge arst_n_i) begin : model
    bit hold;
    int w;
    if (!arst_n_i) begin
      for (int c = 0; c < NCFG; c++) begin
        m_grant[c] = -1;
        m_last[c]  = -1;
      end
    end else if (cke_i) begin
      for (int c = 0; c < NCFG; c++) begin
        hold = 1'b0;
        if (m_grant[c] >= 0) begin
          if (CFG_BLK[c] == 1) hold = request_i[m_grant[c]];
          else if (CFG_BLK[c] == 2) hold = !acknowledge_i[m_grant[c]];
        end
        if (!hold) begin
          w = pick(c, request_i, m_last[c]);
          m_grant[c] = w;
          if (w >= 0 && CFG_RR[c] != 0) m_last[c] = w;
        end
      end
    end
  end

  task automatic applyStimulus(input logic [P-1:0] req, input logic [P-1:0] ack, input logic cke);
    request_i     = req;
    acknowledge_i = ack;
    cke_i         = cke;
  endtask

  task automatic checkOutput(input string name, input int c, input logic [P-1:0] exp_g,
                             input logic [1:0] exp_e);
    logic exp_v;
    exp_v = |exp_g;
    tests++;
    if (grant[c] !== exp_g || valid[c] !== exp_v || enc[c] !== exp_e) begin
      fails++;
      $display("[TB] FAIL %s dut%0d: got grant=%b valid=%b enc=%0d, expected grant=%b valid=%b enc=%0d",
               name, c, grant[c], valid[c], enc[c], exp_g, exp_v, exp_e);
    end
  endtask

  task automatic checkModel(input string name, input int c);
    logic [P-1:0] g;
    logic [1:0]   e;
    g = '0;
    e = '0;
    if (m_grant[c] >= 0) begin
      g[m_grant[c]] = 1'b1;
      e = 2'(m_grant[c]);
    end
    checkOutput(name, c, g, e);
  endtask

  task automatic doReset(input logic [P-1:0] req);
    @(negedge clk_i);
    arst_n_i = 1'b0;
    applyStimulus(req, '0, 1'b1);
    @(negedge clk_i);
    @(negedge clk_i);
    arst_n_i = 1'b1;
  endtask

  task automatic add(input string name, input int dut, input bit rst, input logic [P-1:0] req,
                     input logic [P-1:0] ack, input logic cke, input logic [P-1:0] g,
                     input logic [1:0] e);
    vec_t v;
    v.name = name; v.dut = dut; v.rst = rst; v.req = req; v.ack = ack;
    v.cke = cke; v.exp_grant = g; v.exp_enc = e;
    vecs.push_back(v);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  initial begin
    for (int c = 0; c < NCFG; c++) begin
      m_grant[c] = -1;
      m_last[c]  = -1;
    end

    add("rr_first",    0, 1, 4'b1011, 4'b0000, 1, 4'b0001, 2'd0);
    add("rr_second",   0, 0, 4'b1011, 4'b0000, 1, 4'b0010, 2'd1);
    add("rr_third",    0, 0, 4'b1011, 4'b0000, 1, 4'b1000, 2'd3);
    add("rr_wrap",     0, 0, 4'b1011, 4'b0000, 1, 4'b0001, 2'd0);
    add("fix_a",       1, 1, 4'b1100, 4'b0000, 1, 4'b0100, 2'd2);
    add("fix_b",       1, 0, 4'b1100, 4'b0000, 1, 4'b0100, 2'd2);
    add("fix_drop",    1, 0, 4'b1000, 4'b0000, 1, 4'b1000, 2'd3);
    add("fix_none",    1, 0, 4'b0000, 4'b0000, 1, 4'b0000, 2'd0);
    add("req_grant",   2, 1, 4'b0010, 4'b0000, 1, 4'b0010, 2'd1);
    add("req_hold",    2, 0, 4'b0011, 4'b0000, 1, 4'b0010, 2'd1);
    add("req_hold2",   2, 0, 4'b0011, 4'b0000, 1, 4'b0010, 2'd1);
    add("req_handoff", 2, 0, 4'b0001, 4'b0000, 1, 4'b0001, 2'd0);
    add("req_idle",    2, 0, 4'b0000, 4'b0000, 1, 4'b0000, 2'd0);
    add("ack_grant",   3, 1, 4'b0100, 4'b0000, 1, 4'b0100, 2'd2);
    add("ack_nreq",    3, 0, 4'b0000, 4'b0000, 1, 4'b0100, 2'd2);
    add("ack_other",   3, 0, 4'b0000, 4'b1000, 1, 4'b0100, 2'd2);
    add("ack_release", 3, 0, 4'b0101, 4'b0100, 1, 4'b0001, 2'd0);
    add("ack_hold2",   3, 0, 4'b0101, 4'b0000, 1, 4'b0001, 2'd0);
    add("ack_rotate",  3, 0, 4'b0101, 4'b0001, 1, 4'b0100, 2'd2);
    add("ack_idle",    3, 1, 4'b0000, 4'b1111, 1, 4'b0000, 2'd0);
    add("ack_after",   3, 0, 4'b0010, 4'b0000, 1, 4'b0010, 2'd1);
    add("low_first",   4, 1, 4'b1011, 4'b0000, 1, 4'b1000, 2'd3);
    add("low_second",  4, 0, 4'b1011, 4'b0000, 1, 4'b0010, 2'd1);
    add("low_third",   4, 0, 4'b1011, 4'b0000, 1, 4'b0001, 2'd0);
    add("low_wrap",    4, 0, 4'b1011, 4'b0000, 1, 4'b1000, 2'd3);
    add("cke_grant",   0, 1, 4'b0110, 4'b0000, 1, 4'b0010, 2'd1);
    add("cke_frz1",    0, 0, 4'b1001, 4'b1111, 0, 4'b0010, 2'd1);
    add("cke_frz2",    0, 0, 4'b0001, 4'b0000, 0, 4'b0010, 2'd1);
    add("cke_frz3",    0, 0, 4'b1111, 4'b0000, 0, 4'b0010, 2'd1);
    add("cke_resume",  0, 0, 4'b0110, 4'b0000, 1, 4'b0100, 2'd2);

    // Reset with every port requesting, then the first grant after release
    arst_n_i = 1'b0;
    applyStimulus(4'b1111, 4'b0000, 1'b1);
    @(negedge clk_i);
    for (int c = 0; c < NCFG; c++) checkOutput("in_reset", c, 4'b0000, 2'd0);
    arst_n_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    checkOutput("first_grant", 0, 4'b0001, 2'd0);
    checkOutput("first_grant", 1, 4'b0001, 2'd0);
    checkOutput("first_grant", 2, 4'b0001, 2'd0);
    checkOutput("first_grant", 3, 4'b0001, 2'd0);
    checkOutput("first_grant", 4, 4'b1000, 2'd3);

    for (int k = 0; k < vecs.size(); k++) begin
      if (vecs[k].rst) doReset(vecs[k].req);
      applyStimulus(vecs[k].req, vecs[k].ack, vecs[k].cke);
      @(posedge clk_i);
      @(negedge clk_i);
      checkOutput(vecs[k].name, vecs[k].dut, vecs[k].exp_grant, vecs[k].exp_enc);
    end

    // Asynchronous reset in the middle of a grant, then restart from reset priority
    #2;
    arst_n_i = 1'b0;
    #1;
    for (int c = 0; c < NCFG; c++) checkOutput("async_clear", c, 4'b0000, 2'd0);
    @(negedge clk_i);
    arst_n_i = 1'b1;
    applyStimulus(4'b0110, 4'b0000, 1'b1);
    @(posedge clk_i);
    @(negedge clk_i);
    checkOutput("post_reset", 0, 4'b0010, 2'd1);
    checkOutput("post_reset", 1, 4'b0010, 2'd1);
    checkOutput("post_reset", 4, 4'b0100, 2'd2);

    doReset('0);
    for (int n = 0; n < 600; n++) begin
      applyStimulus(4'($urandom), 4'($urandom & $urandom), ($urandom_range(0, 7) != 0));
      @(posedge clk_i);
      @(negedge clk_i);
      for (int c = 0; c < NCFG; c++) checkModel("random", c);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
